// File: rtl/nand_read_toggle_if.sv
// Stream/control bundle between the NAND read-strobe generator and its
// controller + page buffer. clk/reset stay outside as plain ports.
interface nand_read_toggle_if #(
   parameter int CNT_W  = 12,
   parameter int DATA_W = 8
);
   logic              enable;
   logic              locked;
   logic [CNT_W-1:0]  cnt_upto;
   logic [DATA_W-1:0] dq_in;
   logic              byte_ready;
   logic              re_n;
   logic [DATA_W-1:0] byte_data;
   logic              byte_valid;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  byte_cnt_out;

   modport master (
      output enable, locked, cnt_upto, dq_in, byte_ready,
      input  re_n, byte_data, byte_valid, busy, done, byte_cnt_out
   );

   modport slave (
      input  enable, locked, cnt_upto, dq_in, byte_ready,
      output re_n, byte_data, byte_valid, busy, done, byte_cnt_out
   );
endinterface

// File: rtl/nand_read_toggle.sv
// NAND read-strobe generator: pulses RE_n low for RE_LOW_CYC cycles, captures
// DQ on the rising edge of RE_n into a single-entry valid/ready stream, and
// holds RE_n high while that entry is still occupied.
module nand_read_toggle #(
   parameter int RE_LOW_CYC  = 3,
   parameter int RE_HIGH_CYC = 2,
   parameter int CNT_W       = 12,
   parameter int DATA_W      = 8
) (
   input logic                clk,
   input logic                reset,
   nand_read_toggle_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RE_LOW,
      S_RE_HIGH,
      S_DONE
   } state_t;

   localparam logic [3:0] C_LOW       = 4'(RE_LOW_CYC);
   localparam logic [3:0] C_HIGH      = 4'(RE_HIGH_CYC);
   localparam logic [3:0] C_HIGH_HOLD = 4'(RE_HIGH_CYC - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_delay;
   logic [3:0]        w_delay_nxt;
   logic [3:0]        w_delay_inc;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [CNT_W-1:0]  r_target;
   logic [CNT_W-1:0]  w_target_nxt;
   logic              w_capture;
   logic              w_accept;
   logic              w_stream_free;
   logic              r_re_n;
   logic              r_busy;
   logic              r_done;
   logic              r_byte_valid;
   logic [DATA_W-1:0] r_byte_data;

   // Next-state, counter and capture decisions for the strobe sequence.
   always_comb begin
      w_state_nxt   = r_state;
      w_delay_nxt   = r_delay;
      w_cnt_nxt     = r_byte_cnt;
      w_target_nxt  = r_target;
      w_capture     = 1'b0;
      w_accept      = r_byte_valid & bus.byte_ready;
      w_stream_free = ~r_byte_valid | bus.byte_ready;
      w_delay_inc   = r_delay + 4'd1;

      case (r_state)
         S_IDLE: begin
            w_delay_nxt = '0;
            w_cnt_nxt   = '0;
            if (bus.enable && bus.locked) begin
               w_target_nxt = bus.cnt_upto;
               w_state_nxt  = (bus.cnt_upto == '0) ? S_DONE : S_RE_LOW;
            end
         end
         S_RE_LOW: begin
            if (w_delay_inc == C_LOW) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = r_byte_cnt + CNT_W'(1);
               w_delay_nxt = '0;
               w_state_nxt = S_RE_HIGH;
            end else begin
               w_delay_nxt = w_delay_inc;
            end
         end
         S_RE_HIGH: begin
            if (w_delay_inc >= C_HIGH) begin
               // While stalled the counter parks one short of the limit so
               // the high-width condition keeps holding on later edges.
               w_delay_nxt = C_HIGH_HOLD;
               if (w_stream_free) begin
                  if (r_byte_cnt == r_target) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_state_nxt = S_RE_LOW;
                     w_delay_nxt = '0;
                  end
               end
            end else begin
               w_delay_nxt = w_delay_inc;
            end
         end
         S_DONE: begin
            if (!bus.enable) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_delay_nxt = '0;
         end
      endcase
   end

   // State, delay, byte-count and target registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_delay    <= '0;
         r_byte_cnt <= '0;
         r_target   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_delay    <= w_delay_nxt;
         r_byte_cnt <= w_cnt_nxt;
         r_target   <= w_target_nxt;
      end
   end

   // Registered strobe and status outputs, decoded from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_re_n <= 1'b1;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_re_n <= (w_state_nxt != S_RE_LOW);
         r_busy <= (w_state_nxt == S_RE_LOW) || (w_state_nxt == S_RE_HIGH);
         r_done <= (w_state_nxt == S_DONE);
      end
   end

   // Single-entry output stream: capture sets, acceptance clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte_valid <= 1'b0;
         r_byte_data  <= '0;
      end else if (w_capture) begin
         r_byte_valid <= 1'b1;
         r_byte_data  <= bus.dq_in;
      end else if (w_accept) begin
         r_byte_valid <= 1'b0;
      end
   end

   assign bus.re_n         = r_re_n;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.byte_valid   = r_byte_valid;
   assign bus.byte_data    = r_byte_data;
   assign bus.byte_cnt_out = r_byte_cnt;

endmodule

// File: tb/tb_nand_read_toggle.sv
// Self-checking bench for nand_read_toggle. The reference model predicts the
// pulse schedule from edge arithmetic: pulse k starts at S_k, byte k is
// captured at S_k+LOW and accepted at the first later edge with ready high
// (A_k); the next pulse starts at max(S_k+LOW+HIGH, A_k).
`timescale 1ns/100ps
module tb_nand_read_toggle;
   localparam int LOW  = 3;
   localparam int HIGH = 2;
   localparam int CW   = 12;
   localparam int DW   = 8;
   localparam int MAXE = 512;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   da;
   int   p2;

   nand_read_toggle_if #(.CNT_W(CW), .DATA_W(DW)) bus ();

   nand_read_toggle #(
      .RE_LOW_CYC (LOW),
      .RE_HIGH_CYC(HIGH),
      .CNT_W      (CW),
      .DATA_W     (DW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #2.5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // mode 0: random ready/dq; 1: ready high, dq=A0+pulse; 2: as 1 with a
   // 10-cycle ready stall after the first byte appears.
   task automatic run_xfer(input int n, input int mode, input int pre_lock,
                           input int post_hold, input int abort_at,
                           output int done_at, output int p2_at);
      bit          rdy[MAXE];
      logic [7:0]  dq[MAXE];
      int          s[$];
      int          a[$];
      logic [7:0]  got[$];
      int          falls[$];
      int          t, ac, d, last, ec, er, ev, ecnt;
      logic [31:0] ed;
      logic [7:0]  eb;
      bit          prev_v, prev_re;
      logic [7:0]  prev_d;

      for (int e = 0; e < MAXE; e++) begin
         rdy[e] = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (mode == 2 && e >= 4 && e <= 13) rdy[e] = 1'b0;
         if (e >= 300) rdy[e] = 1'b1;
      end
      t = 0;
      for (int k = 0; k < n; k++) begin
         s.push_back(t);
         ac = t + LOW + 1;
         while (!rdy[ac]) ac++;
         a.push_back(ac);
         t = (t + LOW + HIGH > ac) ? t + LOW + HIGH : ac;
      end
      d = t;
      for (int e = 0; e < MAXE; e++) begin
         if (mode == 0) begin
            dq[e] = 8'($urandom);
         end else begin
            ec = 0;
            foreach (s[k]) if (s[k] <= e) ec++;
            dq[e] = 8'(32'hA0 + ec - 1);
         end
      end

      done_at = -1;
      p2_at   = -1;
      prev_v  = 1'b0;
      prev_d  = '0;
      prev_re = 1'b1;
      bus.enable     = 1'b1;
      bus.cnt_upto   = CW'(n);
      bus.byte_ready = 1'b1;
      bus.locked     = (pre_lock == 0);
      for (int i = 0; i < pre_lock; i++) begin
         @(posedge clk); #1;
         check("gate_re_n", 32'(bus.re_n), 1);
         check("gate_busy", 32'(bus.busy), 0);
         check("gate_done", 32'(bus.done), 0);
         @(negedge clk);
      end
      bus.locked     = 1'b1;
      bus.byte_ready = rdy[0];
      bus.dq_in      = dq[0];

      last = d + post_hold;
      for (int e = 0; e <= last; e++) begin
         @(posedge clk); #1;
         if (prev_v && rdy[e]) got.push_back(prev_d);
         er = 1; ev = 0; ed = '0; ecnt = 0;
         for (int k = 0; k < n; k++) begin
            if (e >= s[k] && e < s[k] + LOW) er = 0;
            if (e >= s[k] + LOW) ecnt++;
            if (e >= s[k] + LOW && e < a[k]) begin
               ev = 1;
               ed = 32'(dq[s[k] + LOW]);
            end
         end
         check("re_n", 32'(bus.re_n), er);
         check("byte_valid", 32'(bus.byte_valid), ev);
         if (ev == 1) check("byte_data", 32'(bus.byte_data), ed);
         check("byte_cnt", 32'(bus.byte_cnt_out), ecnt);
         check("done", 32'(bus.done), (e >= d) ? 1 : 0);
         check("busy", 32'(bus.busy), (e < d) ? 1 : 0);
         if (bus.done === 1'b1 && done_at < 0) done_at = e;
         if (bus.re_n === 1'b0 && prev_re) falls.push_back(e);
         prev_v  = bus.byte_valid;
         prev_d  = bus.byte_data;
         prev_re = bus.re_n;
         if (e == abort_at) begin
            reset = 1'b1;
            #1;
            check("rst_re_n", 32'(bus.re_n), 1);
            check("rst_valid", 32'(bus.byte_valid), 0);
            check("rst_done", 32'(bus.done), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_cnt", 32'(bus.byte_cnt_out), 0);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         @(negedge clk);
         bus.byte_ready = rdy[e + 1];
         bus.dq_in      = dq[e + 1];
         bus.cnt_upto   = CW'($urandom);
         if (mode == 0) bus.locked = 1'($urandom);
      end

      if (falls.size() > 1) p2_at = falls[1];
      check("n_bytes", got.size(), n);
      foreach (got[k]) begin
         if (k < n) begin
            eb = (mode == 0) ? dq[s[k] + LOW] : 8'(32'hA0 + k);
            check("byte_order", 32'(got[k]), 32'(eb));
         end
      end
      check("done_at", done_at, d);
      bus.enable = 1'b0;
      @(posedge clk); #1;
      check("idle_done", 32'(bus.done), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_re_n", 32'(bus.re_n), 1);
      @(negedge clk);
   endtask

   initial begin
      reset          = 1'b1;
      bus.enable     = 1'b0;
      bus.locked     = 1'b0;
      bus.cnt_upto   = '0;
      bus.dq_in      = '0;
      bus.byte_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("por_re_n", 32'(bus.re_n), 1);
      check("por_valid", 32'(bus.byte_valid), 0);
      check("por_data", 32'(bus.byte_data), 0);
      check("por_done", 32'(bus.done), 0);
      check("por_busy", 32'(bus.busy), 0);
      check("por_cnt", 32'(bus.byte_cnt_out), 0);
      @(negedge clk);
      reset = 1'b0;

      run_xfer(4, 1, 0, 0, -1, da, p2);
      check("basic_done_at20", da, 20);

      run_xfer(2, 2, 0, 0, -1, da, p2);
      check("bp_p2_start", p2, 14);

      run_xfer(0, 1, 0, 3, -1, da, p2);
      check("zero_done_at", da, 0);

      run_xfer(3, 1, 8, 6, -1, da, p2);
      check("gate_done_at", da, 15);

      run_xfer(3, 1, 0, 0, 6, da, p2);
      run_xfer(3, 1, 0, 0, -1, da, p2);

      repeat (12) begin
         run_xfer($urandom_range(0, 10), 0, $urandom_range(0, 3),
                  $urandom_range(0, 3), -1, da, p2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
